// File: rtl/file_register_mc.sv
// -----------------------------------------------------------------------------
// file_register_mc
//
// Command decoder and control plane for the soft microcontroller. A 32-bit
// command word {cmd, enable, payload} is written on the micro's GPO; a command
// executes once per rising edge of its enable bit. Results come back on the
// micro's GPI through o_data_to_micro.
//
// Features:
//   - N_CH BER channels, each with four NB_BER-bit counters. A low read latches
//     the whole counter into a shadow register, so the following BER_HIGH read
//     is coherent with it.
//   - Log memory read FSM (IDLE -> RD -> WAIT) tolerant of MEM_LAT clocks of
//     read latency.
//   - Sticky error flag and 16-bit accepted-command counter, read via STATUS.
//
// Ports:
//   clock, reset            system clock, asynchronous active-low reset
//   i_cmd_from_micro        command word {cmd[31:24], enable[23], payload[22:0]}
//   o_data_to_micro         return word (held until a returning command)
//   i_mem_full              log memory full flag
//   i_ber_samp_I/Q          per-channel sample counters, channel c at [c*NB_BER +: NB_BER]
//   i_ber_error_I/Q         per-channel error counters, same packing
//   i_data_log_from_mem     log memory read data
//   o_reset, o_enbTx        soft reset, TX enable
//   o_enbRx                 per-channel RX enable
//   o_phase_sel             per-channel phase, channel c at [c*NB_PHASE +: NB_PHASE]
//   o_run_log               log capture run
//   o_read_log              one-cycle read strobe
//   o_addr_log_to_mem       log memory read address
// -----------------------------------------------------------------------------
module file_register_mc #(
    parameter int NB_COM   = 8,
    parameter int NB_DATA  = 24,
    parameter int NB_INST  = 32,
    parameter int NB_BER   = 64,
    parameter int N_CH     = 2,
    parameter int NB_PHASE = 2,
    parameter int NB_ADDR  = 15,
    parameter int MEM_LAT  = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NB_INST-1:0]       i_cmd_from_micro,
    output logic [NB_INST-1:0]       o_data_to_micro,
    input  logic                     i_mem_full,
    input  logic [N_CH*NB_BER-1:0]   i_ber_samp_I,
    input  logic [N_CH*NB_BER-1:0]   i_ber_samp_Q,
    input  logic [N_CH*NB_BER-1:0]   i_ber_error_I,
    input  logic [N_CH*NB_BER-1:0]   i_ber_error_Q,
    input  logic [NB_INST-1:0]       i_data_log_from_mem,
    output logic                     o_reset,
    output logic                     o_enbTx,
    output logic [N_CH-1:0]          o_enbRx,
    output logic [N_CH*NB_PHASE-1:0] o_phase_sel,
    output logic                     o_run_log,
    output logic                     o_read_log,
    output logic [NB_ADDR-1:0]       o_addr_log_to_mem
);

    localparam int NB_PAY = NB_DATA - 1;
    localparam int CH_W   = 5;
    localparam int LAT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);

    localparam logic [NB_COM-1:0] OP_NOP      = NB_COM'(8'h00);
    localparam logic [NB_COM-1:0] OP_RESET    = NB_COM'(8'h01);
    localparam logic [NB_COM-1:0] OP_EN_TX    = NB_COM'(8'h02);
    localparam logic [NB_COM-1:0] OP_EN_RX    = NB_COM'(8'h03);
    localparam logic [NB_COM-1:0] OP_PH_SEL   = NB_COM'(8'h04);
    localparam logic [NB_COM-1:0] OP_RUN_MEM  = NB_COM'(8'h05);
    localparam logic [NB_COM-1:0] OP_RD_MEM   = NB_COM'(8'h06);
    localparam logic [NB_COM-1:0] OP_IS_FULL  = NB_COM'(8'h07);
    localparam logic [NB_COM-1:0] OP_BER_S_I  = NB_COM'(8'h08);
    localparam logic [NB_COM-1:0] OP_BER_S_Q  = NB_COM'(8'h09);
    localparam logic [NB_COM-1:0] OP_BER_E_I  = NB_COM'(8'h0A);
    localparam logic [NB_COM-1:0] OP_BER_E_Q  = NB_COM'(8'h0B);
    localparam logic [NB_COM-1:0] OP_BER_HIGH = NB_COM'(8'h0C);
    localparam logic [NB_COM-1:0] OP_STATUS   = NB_COM'(8'h0D);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // Command word fields
    logic [NB_COM-1:0]   cmd;
    logic                enable;
    logic [NB_PAY-1:0]   payload;
    logic [CH_W-1:0]     ch;
    logic                val;
    logic [NB_PHASE-1:0] ph;
    logic [NB_ADDR-1:0]  addr;
    logic                unused_payload;

    assign cmd     = i_cmd_from_micro[NB_INST-1 -: NB_COM];
    assign enable  = i_cmd_from_micro[NB_DATA-1];
    assign payload = i_cmd_from_micro[NB_PAY-1:0];
    assign ch      = payload[20:16];
    assign val     = payload[0];
    assign ph      = payload[NB_PHASE-1:0];
    assign addr    = payload[NB_ADDR-1:0];
    // Not every payload bit is meaningful for every opcode.
    assign unused_payload = ^payload;

    // State
    state_t                    state_q,     state_d;
    logic [LAT_W-1:0]          lat_cnt_q,   lat_cnt_d;
    logic                      en_prev_q;
    logic [NB_INST-1:0]        data_q,      data_d;
    logic                      reset_q,     reset_d;
    logic                      enb_tx_q,    enb_tx_d;
    logic [N_CH-1:0]           enb_rx_q,    enb_rx_d;
    logic [N_CH*NB_PHASE-1:0]  phase_q,     phase_d;
    logic                      run_log_q,   run_log_d;
    logic                      read_log_q,  read_log_d;
    logic [NB_ADDR-1:0]        addr_q,      addr_d;
    logic [NB_BER-1:0]         shadow_q,    shadow_d;
    logic                      err_q,       err_d;
    logic [15:0]               cmd_count_q, cmd_count_d;

    logic              cmd_edge;
    logic              busy;
    logic              ch_ok;
    logic              bad;
    logic [NB_BER-1:0] ber_sel;

    assign cmd_edge = enable & ~en_prev_q;
    assign busy     = (state_q != ST_IDLE);

    // Channel range check and counter mux; the loop avoids indexing the packed
    // buses with the 5-bit channel field when N_CH is smaller than 32.
    always_comb begin
        ch_ok   = 1'b0;
        ber_sel = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (ch == CH_W'(c)) begin
                ch_ok = 1'b1;
                case (cmd[1:0])
                    2'b00:   ber_sel = i_ber_samp_I [c*NB_BER +: NB_BER];
                    2'b01:   ber_sel = i_ber_samp_Q [c*NB_BER +: NB_BER];
                    2'b10:   ber_sel = i_ber_error_I[c*NB_BER +: NB_BER];
                    default: ber_sel = i_ber_error_Q[c*NB_BER +: NB_BER];
                endcase
            end
        end
    end

    // NOTE: every variable driven here gets its hold value first, so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        data_d      = data_q;
        reset_d     = reset_q;
        enb_tx_d    = enb_tx_q;
        enb_rx_d    = enb_rx_q;
        phase_d     = phase_q;
        run_log_d   = run_log_q;
        read_log_d  = 1'b0;
        addr_d      = addr_q;
        shadow_d    = shadow_q;
        err_d       = err_q;
        cmd_count_d = cmd_count_q;
        bad         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_edge) begin
                    case (cmd)
                        OP_NOP:     ;
                        OP_RESET:   reset_d   = val;
                        OP_EN_TX:   enb_tx_d  = val;
                        OP_RUN_MEM: run_log_d = val;
                        OP_EN_RX: begin
                            if (ch_ok) begin
                                for (int c = 0; c < N_CH; c++)
                                    if (ch == CH_W'(c)) enb_rx_d[c] = val;
                            end else begin
                                bad = 1'b1;
                            end
                        end
                        OP_PH_SEL: begin
                            if (ch_ok) begin
                                for (int c = 0; c < N_CH; c++)
                                    if (ch == CH_W'(c)) phase_d[c*NB_PHASE +: NB_PHASE] = ph;
                            end else begin
                                bad = 1'b1;
                            end
                        end
                        OP_RD_MEM: begin
                            state_d    = ST_RD;
                            read_log_d = 1'b1;
                            addr_d     = addr;
                        end
                        OP_IS_FULL: data_d = NB_INST'(i_mem_full);
                        OP_BER_S_I, OP_BER_S_Q, OP_BER_E_I, OP_BER_E_Q: begin
                            if (ch_ok) begin
                                shadow_d = ber_sel;
                                data_d   = ber_sel[NB_INST-1:0];
                            end else begin
                                bad = 1'b1;
                            end
                        end
                        // Upper half comes from the shadow, never the live counter.
                        OP_BER_HIGH: data_d = NB_INST'(shadow_q[NB_BER-1:NB_INST]);
                        OP_STATUS: begin
                            data_d = NB_INST'({cmd_count_q, 13'b0, err_q, busy, i_mem_full});
                            err_d  = 1'b0;
                        end
                        default: bad = 1'b1;
                    endcase

                    if (bad) err_d = 1'b1;
                    else     cmd_count_d = cmd_count_q + 16'd1;
                end
            end

            ST_RD: begin
                state_d   = ST_WAIT;
                lat_cnt_d = '0;
                if (cmd_edge) err_d = 1'b1;
            end

            ST_WAIT: begin
                if (lat_cnt_q == LAT_LAST) begin
                    data_d  = i_data_log_from_mem;
                    state_d = ST_IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
                // The capture edge is still busy: an edge here is rejected.
                if (cmd_edge) err_d = 1'b1;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            lat_cnt_q   <= '0;
            en_prev_q   <= 1'b0;
            data_q      <= '0;
            reset_q     <= 1'b0;
            enb_tx_q    <= 1'b0;
            enb_rx_q    <= '0;
            phase_q     <= '0;
            run_log_q   <= 1'b0;
            read_log_q  <= 1'b0;
            addr_q      <= '0;
            shadow_q    <= '0;
            err_q       <= 1'b0;
            cmd_count_q <= '0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            en_prev_q   <= enable;
            data_q      <= data_d;
            reset_q     <= reset_d;
            enb_tx_q    <= enb_tx_d;
            enb_rx_q    <= enb_rx_d;
            phase_q     <= phase_d;
            run_log_q   <= run_log_d;
            read_log_q  <= read_log_d;
            addr_q      <= addr_d;
            shadow_q    <= shadow_d;
            err_q       <= err_d;
            cmd_count_q <= cmd_count_d;
        end
    end

    assign o_data_to_micro   = data_q;
    assign o_reset           = reset_q;
    assign o_enbTx           = enb_tx_q;
    assign o_enbRx           = enb_rx_q;
    assign o_phase_sel       = phase_q;
    assign o_run_log         = run_log_q;
    assign o_read_log        = read_log_q;
    assign o_addr_log_to_mem = addr_q;

endmodule
